mmio_uart_tx: RTL and testbench
===============================

# mmio_uart_tx

Memory-mapped UART transmitter on the single-cycle core's data-store bus, alongside the data memory. Decodes core stores to its register window, queues low bytes in a small FIFO and serialises them 8N1 on a `tx` line. Exposes a combinational status word the core top muxes into its load-data path.

## Interface
Parameters:
- `BASE_ADDR`, 32'h0000_1000: word address of TXDATA; STATUS is `BASE_ADDR+4`.
- `CLKS_PER_BIT`, 16: clock cycles per serial bit; must be ≥2.
- `FIFO_DEPTH`, 8: byte entries; power of two, ≥2.

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low; all state clears while low.
- `MemWrite`  in  1  core store strobe.
- `DataAdr`  in  32  core ALU result / bus address.
- `WriteData`  in  32  core store data.
- `StatusData`  out  32  combinational status word (layout below).
- `tx`  out  1  serial output, registered, idle high.

## Operation
- Push: `MemWrite && DataAdr==BASE_ADDR`; `WriteData[7:0]` enters FIFO on that edge. Upper bits ignored.
- Push while FIFO full (judged before the edge): byte dropped, sticky `overflow` set. A same-edge pop does not rescue it.
- Clear: `MemWrite && DataAdr==BASE_ADDR+4` clears `overflow`; data ignored. Stores elsewhere ignored.
- StatusData = {24'b0, count[3:0], overflow, empty, full, busy}; bit0 busy (FSM not IDLE), bit1 full, bit2 empty, bit3 overflow, bits[7:4] FIFO occupancy (saturating field; DEPTH ≤15 assumed legal only). Valid regardless of `DataAdr`; core top selects it.
- FSM: IDLE → START → DATA → STOP → IDLE/START.
  - IDLE: `tx`=1; if FIFO non-empty, pop into shift register, go START.
  - START: `tx`=0 for CLKS_PER_BIT cycles.
  - DATA: 8 bits LSB first, CLKS_PER_BIT cycles each; 3-bit bit index.
  - STOP: `tx`=1 for CLKS_PER_BIT cycles; at its end, pop and go START if non-empty (no idle gap), else IDLE.
- Baud counter counts 0..CLKS_PER_BIT-1, reloads at each bit boundary; width $clog2(CLKS_PER_BIT).
- FIFO pointers $clog2(FIFO_DEPTH)+1 bits, wrap naturally; full when pointers differ only in MSB.

## Timing
- Reset values: `tx`=1, FSM IDLE, FIFO empty, overflow 0, StatusData = 32'h0000_0004.
- Push at edge N → `empty`=0 after N; IDLE pops at edge N+1; `tx` low from N+1 (registered output).
- Frame = 10·CLKS_PER_BIT cycles; back-to-back frames contiguous.
- Simultaneous push and pop on non-full FIFO: both occur, count unchanged.
- Reset asserted mid-frame: `tx` forced 1 immediately, queued bytes discarded.
- StatusData: zero-cycle combinational from state registers.

## Configuration
- `MMIO_UART_PARITY_EN` defined: PARITY state between DATA and STOP transmits even parity (XOR of 8 data bits); frame = 11·CLKS_PER_BIT cycles.
- Undefined: no parity state; 8N1, 10-bit frame.

## Structure
- Package `mmio_uart_pkg`: FSM state enum, TXDATA/STATUS offsets (0, 4), status bit-index constants.
- Sub-module `sync_fifo` (parameterised width/depth, push/pop/full/empty/count); FSM, decode, status in top module.

## Test plan
- Reset release → `tx`=1, StatusData=32'h4, no transitions for 100 cycles.
- Store 32'hFFFF_FF55 to 0x1000, CLKS_PER_BIT=4 → `tx`: 0,1,0,1,0,1,0,1,0,1 each 4 cycles; busy 1 for 40 cycles.
- Two consecutive stores 0x41,0x42 → two contiguous 40-cycle frames, no idle gap; empty=1 after second pop.
- Nine stores in 9 cycles, DEPTH 8 → first byte popped, 8 queued, none dropped; tenth store while full → overflow=1; store to 0x1004 → overflow=0.
- Reset low mid-DATA → `tx`=1 same cycle, StatusData=32'h4 after release.
- With `MMIO_UART_PARITY_EN`, byte 0x07 → parity bit 1, 44-cycle frame at CLKS_PER_BIT=4.

Source files
------------

// File: rtl/mmio_uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: FSM state
// encoding, register-window offsets and StatusData bit positions.
package mmio_uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  localparam logic [31:0] TXDATA_OFS = 32'd0;
  localparam logic [31:0] STATUS_OFS = 32'd4;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_FULL    = 1;
  localparam int STAT_EMPTY   = 2;
  localparam int STAT_OVF     = 3;
  localparam int STAT_CNT_LSB = 4;

  // Occupancy is reported in a 4-bit field; larger counts pin at 15.
  function automatic logic [3:0] sat_count4(input logic [31:0] c);
    if (c > 32'd15) return 4'hF;
    return c[3:0];
  endfunction

endpackage

// File: rtl/mmio_uart_tx_sync_fifo.sv
// Single-clock FIFO for the UART transmit queue. Pointers carry one extra
// wrap bit so full/empty are distinguished without a separate counter.
// Push while full and pop while empty are ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int PW = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [PW-1:0]    count
);

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             do_push, do_pop;

  // Flags and read port come straight from the pointers and storage.
  always_comb begin
    full    = (wr_ptr_q ^ rd_ptr_q) == {1'b1, {AW{1'b0}}};
    empty   = (wr_ptr_q == rd_ptr_q);
    count   = wr_ptr_q - rd_ptr_q;
    rdata   = mem_q[rd_ptr_q[AW-1:0]];
    do_push = push && !full;
    do_pop  = pop && !empty;
  end

  // Next pointer and storage values for a push and/or pop this cycle.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (do_push) begin
      mem_d[wr_ptr_q[AW-1:0]] = wdata;
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
  end

  // Pointer and storage registers; reset discards all queued entries.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter. Stores to TXDATA queue a byte, stores to
// STATUS clear the sticky overflow flag; bytes are sent 8N1 on tx.
// Build option MMIO_UART_PARITY_EN inserts an even-parity bit before STOP.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | line idle high, waiting for a queued byte
// ST_START  | start bit (low) for CLKS_PER_BIT cycles
// ST_DATA   | eight data bits, LSB first, CLKS_PER_BIT cycles each
// ST_PARITY | even parity of the data byte (parity builds only)
// ST_STOP   | stop bit (high); chains straight into the next frame
module mmio_uart_tx
  import mmio_uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_1000,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] DataAdr,
  input  logic [31:0] WriteData,
  output logic [31:0] StatusData,
  output logic        tx
);

  localparam int                CNT_W     = $clog2(CLKS_PER_BIT);
  localparam int                PW        = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0]  BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);

  uart_state_e      state_q, state_d;
  logic [CNT_W-1:0] baud_cnt_q, baud_cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       frame_byte_q, frame_byte_d;
  logic             overflow_q, overflow_d;
  logic             tx_q, tx_d;
  logic             busy;
  logic             baud_end;

  logic             wr_txdata, wr_status;
  logic             fifo_pop;
  logic [7:0]       fifo_rdata;
  logic             fifo_full, fifo_empty;
  logic [PW-1:0]    fifo_count;

  // Only the low byte of a TXDATA store is transmitted.
  logic unused_wdata;
  assign unused_wdata = ^WriteData[31:8];

  // A push that meets a full FIFO is dropped inside the FIFO.
  sync_fifo #(
    .WIDTH(8),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (wr_txdata),
    .wdata (WriteData[7:0]),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Address decode and sticky overflow; full is judged on pre-edge state.
  always_comb begin
    wr_txdata  = MemWrite && (DataAdr == BASE_ADDR + TXDATA_OFS);
    wr_status  = MemWrite && (DataAdr == BASE_ADDR + STATUS_OFS);
    overflow_d = overflow_q;
    if (wr_status) overflow_d = 1'b0;
    if (wr_txdata && fifo_full) overflow_d = 1'b1;
  end

  // State and datapath registers; reset returns the line to idle high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      baud_cnt_q   <= '0;
      bit_idx_q    <= '0;
      frame_byte_q <= '0;
      overflow_q   <= 1'b0;
      tx_q         <= 1'b1;
    end else begin
      state_q      <= state_d;
      baud_cnt_q   <= baud_cnt_d;
      bit_idx_q    <= bit_idx_d;
      frame_byte_q <= frame_byte_d;
      overflow_q   <= overflow_d;
      tx_q         <= tx_d;
    end
  end

  // Next-state logic: bit timing, bit index and FIFO pops.
  always_comb begin
    state_d      = state_q;
    baud_cnt_d   = baud_cnt_q;
    bit_idx_d    = bit_idx_q;
    frame_byte_d = frame_byte_q;
    fifo_pop     = 1'b0;
    baud_end     = (baud_cnt_q == BAUD_LAST);
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop     = 1'b1;
          frame_byte_d = fifo_rdata;
          baud_cnt_d   = '0;
          state_d      = ST_START;
        end
      end
      ST_START: begin
        if (baud_end) begin
          baud_cnt_d = '0;
          bit_idx_d  = '0;
          state_d    = ST_DATA;
        end else begin
          baud_cnt_d = baud_cnt_q + CNT_W'(1);
        end
      end
      ST_DATA: begin
        if (baud_end) begin
          baud_cnt_d = '0;
          if (bit_idx_q == 3'd7) begin
`ifdef MMIO_UART_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          baud_cnt_d = baud_cnt_q + CNT_W'(1);
        end
      end
`ifdef MMIO_UART_PARITY_EN
      ST_PARITY: begin
        if (baud_end) begin
          baud_cnt_d = '0;
          state_d    = ST_STOP;
        end else begin
          baud_cnt_d = baud_cnt_q + CNT_W'(1);
        end
      end
`endif
      ST_STOP: begin
        if (baud_end) begin
          baud_cnt_d = '0;
          if (!fifo_empty) begin
            fifo_pop     = 1'b1;
            frame_byte_d = fifo_rdata;
            state_d      = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          baud_cnt_d = baud_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        baud_cnt_d = '0;
        state_d    = ST_IDLE;
      end
    endcase
  end

  // Line level is computed from the next state so tx is registered yet
  // changes on the same edge the state does.
  always_comb begin
    busy = (state_q != ST_IDLE);
    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = frame_byte_d[bit_idx_d];
`ifdef MMIO_UART_PARITY_EN
      ST_PARITY: tx_d = ^frame_byte_d;
`endif
      default:   tx_d = 1'b1;
    endcase
  end

  // Status word presented combinationally for the core's load mux.
  always_comb begin
    StatusData                              = '0;
    StatusData[STAT_BUSY]                   = busy;
    StatusData[STAT_FULL]                   = fifo_full;
    StatusData[STAT_EMPTY]                  = fifo_empty;
    StatusData[STAT_OVF]                    = overflow_q;
    StatusData[STAT_CNT_LSB+3:STAT_CNT_LSB] = sat_count4(32'(fifo_count));
  end

  assign tx = tx_q;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx at CLKS_PER_BIT=4, FIFO_DEPTH=8.
module tb_mmio_uart_tx;

  localparam int CPB   = 4;
`ifdef MMIO_UART_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FCYC  = NBITS * CPB;

  logic        clk;
  logic        reset;
  logic        MemWrite;
  logic [31:0] DataAdr;
  logic [31:0] WriteData;
  logic [31:0] StatusData;
  logic        tx;

  int n_checks = 0;
  int n_pass   = 0;

  mmio_uart_tx #(
    .BASE_ADDR   (32'h0000_1000),
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .MemWrite  (MemWrite),
    .DataAdr   (DataAdr),
    .WriteData (WriteData),
    .StatusData(StatusData),
    .tx        (tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected line level for frame bit k of byte b.
  function automatic logic exp_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    if (k == NBITS - 1) return 1'b1;
    return ^b;
  endfunction

  // One-cycle store; call and return at a falling edge.
  task automatic store(input logic [31:0] a, input logic [31:0] d);
    MemWrite  = 1'b1;
    DataAdr   = a;
    WriteData = d;
    @(negedge clk);
    MemWrite  = 1'b0;
    DataAdr   = 32'h0;
    WriteData = 32'h0;
  endtask

  task automatic test_reset;
    int glitches;
    reset = 1'b0; MemWrite = 1'b0; DataAdr = '0; WriteData = '0;
    @(negedge clk); @(negedge clk);
    n_checks++;
    if (tx !== 1'b1) $display("FAIL reset_tx: got %b expected 1", tx);
    else n_pass++;
    n_checks++;
    if (StatusData !== 32'h4) $display("FAIL reset_status: got %h expected 00000004", StatusData);
    else n_pass++;
    reset = 1'b1;
    glitches = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || StatusData !== 32'h4) glitches++;
    end
    n_checks++;
    if (glitches !== 0) $display("FAIL idle_100: got %0d bad cycles expected 0", glitches);
    else n_pass++;
  endtask

  task automatic test_decode;
    MemWrite = 1'b0; DataAdr = 32'h1000; WriteData = 32'h11;
    @(negedge clk);
    DataAdr = 32'h0;
    n_checks++;
    if (StatusData !== 32'h4) $display("FAIL no_strobe: got %h expected 00000004", StatusData);
    else n_pass++;
    store(32'h0000_1008, 32'h22);
    n_checks++;
    if (StatusData !== 32'h4) $display("FAIL addr_1008: got %h expected 00000004", StatusData);
    else n_pass++;
    store(32'h0000_0FFC, 32'h33);
    n_checks++;
    if (StatusData !== 32'h4) $display("FAIL addr_0ffc: got %h expected 00000004", StatusData);
    else n_pass++;
    store(32'h0001_1000, 32'h44);
    n_checks++;
    if (StatusData !== 32'h4 || tx !== 1'b1)
      $display("FAIL addr_11000: got status %h tx %b expected 00000004 1", StatusData, tx);
    else n_pass++;
  endtask

  task automatic test_single_frame;
    int bad;
    store(32'h0000_1000, 32'hFFFF_FF55);
    n_checks++;
    if (StatusData !== 32'h10) $display("FAIL push_status: got %h expected 00000010", StatusData);
    else n_pass++;
    n_checks++;
    if (tx !== 1'b1) $display("FAIL push_tx_idle: got %b expected 1", tx);
    else n_pass++;
    @(negedge clk);
    bad = 0;
    for (int i = 0; i < FCYC; i++) begin
      if (tx !== exp_bit(8'h55, i / CPB)) bad++;
      if (StatusData[0] !== 1'b1) bad++;
      @(negedge clk);
    end
    n_checks++;
    if (bad !== 0) $display("FAIL frame_55: got %0d bad cycles expected 0", bad);
    else n_pass++;
    n_checks++;
    if (StatusData !== 32'h4 || tx !== 1'b1)
      $display("FAIL frame_55_end: got status %h tx %b expected 00000004 1", StatusData, tx);
    else n_pass++;
  endtask

  task automatic test_back_to_back;
    int bad;
    logic [7:0] b;
    store(32'h0000_1000, 32'h41);
    store(32'h0000_1000, 32'h42);
    n_checks++;
    if (StatusData !== 32'h11) $display("FAIL b2b_status: got %h expected 00000011", StatusData);
    else n_pass++;
    bad = 0;
    for (int i = 0; i < 2 * FCYC; i++) begin
      b = (i < FCYC) ? 8'h41 : 8'h42;
      if (tx !== exp_bit(b, (i % FCYC) / CPB) || StatusData[0] !== 1'b1) bad++;
      if (i == FCYC - 1) begin
        n_checks++;
        if (StatusData[2] !== 1'b0) $display("FAIL b2b_empty_before: got %b expected 0", StatusData[2]);
        else n_pass++;
      end
      if (i == FCYC) begin
        n_checks++;
        if (StatusData !== 32'h5) $display("FAIL b2b_empty_after: got %h expected 00000005", StatusData);
        else n_pass++;
      end
      @(negedge clk);
    end
    n_checks++;
    if (bad !== 0) $display("FAIL b2b_frames: got %0d bad cycles expected 0", bad);
    else n_pass++;
    n_checks++;
    if (StatusData !== 32'h4) $display("FAIL b2b_end: got %h expected 00000004", StatusData);
    else n_pass++;
  endtask

  task automatic test_overflow;
    int bad;
    for (int k = 1; k <= 9; k++) store(32'h0000_1000, 32'(k));
    n_checks++;
    if (StatusData !== 32'h83) $display("FAIL nine_full: got %h expected 00000083", StatusData);
    else n_pass++;
    store(32'h0000_1000, 32'hAA);
    n_checks++;
    if (StatusData !== 32'h8B) $display("FAIL overflow_set: got %h expected 0000008b", StatusData);
    else n_pass++;
    store(32'h0000_1004, 32'hFFFF_FFFF);
    n_checks++;
    if (StatusData !== 32'h83) $display("FAIL overflow_clr: got %h expected 00000083", StatusData);
    else n_pass++;
    store(32'h0000_1008, 32'h5);
    n_checks++;
    if (StatusData !== 32'h83) $display("FAIL stray_store: got %h expected 00000083", StatusData);
    else n_pass++;
    // Frame 0 started at the second store; 10 cycles have passed since.
    bad = 0;
    for (int i = 10; i < 9 * FCYC; i++) begin
      if (tx !== exp_bit(8'((i / FCYC) + 1), (i % FCYC) / CPB)) bad++;
      @(negedge clk);
    end
    n_checks++;
    if (bad !== 0) $display("FAIL drain_order: got %0d bad cycles expected 0", bad);
    else n_pass++;
    n_checks++;
    if (StatusData !== 32'h4) $display("FAIL drain_end: got %h expected 00000004", StatusData);
    else n_pass++;
  endtask

  task automatic test_reset_mid;
    int glitches;
    store(32'h0000_1000, 32'hA5);
    store(32'h0000_1000, 32'h3C);
    repeat (9) @(negedge clk);
    n_checks++;
    if (tx !== 1'b0) $display("FAIL mid_data_low: got %b expected 0", tx);
    else n_pass++;
    reset = 1'b0;
    #1;
    n_checks++;
    if (tx !== 1'b1) $display("FAIL mid_reset_tx: got %b expected 1", tx);
    else n_pass++;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if (StatusData !== 32'h4) $display("FAIL mid_reset_status: got %h expected 00000004", StatusData);
    else n_pass++;
    glitches = 0;
    for (int i = 0; i < 2 * FCYC; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || StatusData !== 32'h4) glitches++;
    end
    n_checks++;
    if (glitches !== 0) $display("FAIL queue_discarded: got %0d bad cycles expected 0", glitches);
    else n_pass++;
  endtask

`ifdef MMIO_UART_PARITY_EN
  task automatic test_parity;
    int bad;
    store(32'h0000_1000, 32'h07);
    @(negedge clk);
    bad = 0;
    for (int i = 0; i < 44; i++) begin
      if (tx !== exp_bit(8'h07, i / CPB) || StatusData[0] !== 1'b1) bad++;
      if (i == 37) begin
        n_checks++;
        if (tx !== 1'b1) $display("FAIL parity_bit: got %b expected 1", tx);
        else n_pass++;
      end
      @(negedge clk);
    end
    n_checks++;
    if (bad !== 0) $display("FAIL parity_frame: got %0d bad cycles expected 0", bad);
    else n_pass++;
    n_checks++;
    if (StatusData !== 32'h4) $display("FAIL parity_end: got %h expected 00000004", StatusData);
    else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_decode();
    test_single_frame();
    test_back_to_back();
    test_overflow();
    test_reset_mid();
`ifdef MMIO_UART_PARITY_EN
    test_parity();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
